// File: rtl/layer0_input_quantizer.sv
// rtl/layer0_input_quantizer.sv - shift/offset/clip quantizer packing NF samples into a double-buffered frame
// Optional saturation counter: define LAYER0_IN_SAT_CNT_EN to add the sat_count port.
module layer0_input_quantizer #(
    parameter int NF    = 32,
    parameter int DW    = 16,
    parameter int QB    = 2,
    parameter int SHIFT = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [DW-1:0]        s_data,
    input  logic                 s_last,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [NF*QB-1:0]     m_data,
    output logic                 frame_err
`ifdef LAYER0_IN_SAT_CNT_EN
    ,
    output logic [15:0]          sat_count
`endif
);

    localparam int IW = (NF > 1) ? $clog2(NF) : 1;
    localparam int QW = DW + 1;
    localparam logic signed [QW-1:0] Q_OFF    = QW'(2 ** (QB - 1));
    localparam logic signed [QW-1:0] Q_LIMIT  = QW'(2 ** QB - 1);
    localparam logic [QB-1:0]        Q_MAX    = {QB{1'b1}};
    localparam logic [IW-1:0]        IDX_LAST = IW'(NF - 1);

    typedef enum logic [0:0] {
        ST_FILL,
        ST_WAIT
    } state_t;

    state_t               state_q, state_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [NF*QB-1:0]     fill_q, fill_d;
    logic [NF*QB-1:0]     m_data_q, m_data_d;
    logic                 m_valid_q, m_valid_d;
    logic                 frame_err_q, frame_err_d;

    logic signed [DW-1:0] y_shift;
    logic signed [QW-1:0] q_ext;
    logic                 sat_hi;
    logic                 sat_lo;
    logic [QB-1:0]        q_val;
    logic [NF*QB-1:0]     fill_next;
    logic                 accept;
    logic                 at_last;
    logic                 complete;
    logic                 align_err;
    logic                 out_take;
    logic                 out_free;

    // Sign-extend by one bit so the offset add can never wrap.
    assign y_shift = $signed(s_data) >>> SHIFT;
    assign q_ext   = $signed({y_shift[DW-1], y_shift}) + Q_OFF;
    assign sat_lo  = q_ext[QW-1];
    assign sat_hi  = !sat_lo && (q_ext > Q_LIMIT);

    always_comb begin
        q_val = q_ext[QB-1:0];
        if (sat_lo) begin
            q_val = '0;
        end else if (sat_hi) begin
            q_val = Q_MAX;
        end
    end

    always_comb begin
        fill_next = fill_q;
        fill_next[idx_q*QB +: QB] = q_val;
    end

    // rst gates s_ready directly so nothing is accepted while reset is held.
    assign s_ready   = (state_q == ST_FILL) && !rst;
    assign accept    = s_valid && s_ready;
    assign at_last   = (idx_q == IDX_LAST);
    assign complete  = accept && at_last && s_last;
    assign align_err = accept && (at_last != s_last);
    assign out_take  = m_valid_q && m_ready;
    assign out_free  = !m_valid_q || m_ready;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        fill_d      = fill_q;
        m_data_d    = m_data_q;
        m_valid_d   = m_valid_q;
        frame_err_d = 1'b0;

        if (out_take) begin
            m_valid_d = 1'b0;
        end

        case (state_q)
            ST_FILL: begin
                if (accept) begin
                    fill_d = fill_next;
                    idx_d  = idx_q + 1'b1;
                    if (align_err) begin
                        idx_d       = '0;
                        frame_err_d = 1'b1;
                    end else if (complete) begin
                        idx_d = '0;
                        if (out_free) begin
                            m_data_d  = fill_next;
                            m_valid_d = 1'b1;
                        end else begin
                            state_d = ST_WAIT;
                        end
                    end
                end
            end
            ST_WAIT: begin
                if (out_take) begin
                    m_data_d  = fill_q;
                    m_valid_d = 1'b1;
                    state_d   = ST_FILL;
                end
            end
            default: begin
                state_d = ST_FILL;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_FILL;
            idx_q       <= '0;
            fill_q      <= '0;
            m_data_q    <= '0;
            m_valid_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            fill_q      <= fill_d;
            m_data_q    <= m_data_d;
            m_valid_q   <= m_valid_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign m_data    = m_data_q;
    assign m_valid   = m_valid_q;
    assign frame_err = frame_err_q;

`ifdef LAYER0_IN_SAT_CNT_EN
    logic [15:0] sat_cnt_q, sat_cnt_d;
    logic        q_sat;

    assign q_sat = sat_lo || sat_hi;

    // Counts every accepted clipped sample, including those of discarded frames.
    always_comb begin
        sat_cnt_d = sat_cnt_q;
        if (accept && q_sat && (sat_cnt_q != 16'hFFFF)) begin
            sat_cnt_d = sat_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sat_cnt_q <= '0;
        end else begin
            sat_cnt_q <= sat_cnt_d;
        end
    end

    assign sat_count = sat_cnt_q;
`endif

endmodule

// File: tb/tb_layer0_input_quantizer.sv
// tb/tb_layer0_input_quantizer.sv - directed-vector bench for layer0_input_quantizer (NF=4, QB=2, SHIFT=8)
module tb_layer0_input_quantizer;

    localparam int NF = 4;
    localparam int DW = 16;
    localparam int QB = 2;
    localparam int SHIFT = 8;

    logic              clk;
    logic              rst;
    logic              s_valid;
    logic              s_ready;
    logic [DW-1:0]     s_data;
    logic              s_last;
    logic              m_valid;
    logic              m_ready;
    logic [NF*QB-1:0]  m_data;
    logic              frame_err;
`ifdef LAYER0_IN_SAT_CNT_EN
    logic [15:0]       sat_count;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    layer0_input_quantizer #(
        .NF(NF), .DW(DW), .QB(QB), .SHIFT(SHIFT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .s_last    (s_last),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .frame_err (frame_err)
`ifdef LAYER0_IN_SAT_CNT_EN
        ,
        .sat_count (sat_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [DW-1:0] d, input logic l);
        int n;
        n = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        while (!s_ready && n < 50) begin
            tick();
            n++;
        end
        if (!s_ready) begin
            check("push_timeout", 32'(s_ready), 32'd1);
        end
        tick();
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    initial begin
        rst     = 1'b1;
        s_valid = 1'b0;
        s_data  = '0;
        s_last  = 1'b0;
        m_ready = 1'b1;
        tick();
        tick();
        check("rst_s_ready", 32'(s_ready), 32'd0);
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_m_data", 32'(m_data), 32'h0);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        rst = 1'b0;
        #1;
        check("release_s_ready", 32'(s_ready), 32'd1);
        tick();

        // Basic frame: features 2,3,1,0
        push(16'h0000, 1'b0);
        push(16'h0100, 1'b0);
        push(16'hFF00, 1'b0);
        push(16'h8000, 1'b1);
        check("basic_m_valid", 32'(m_valid), 32'd1);
        check("basic_m_data", 32'(m_data), 32'h1E);
`ifdef LAYER0_IN_SAT_CNT_EN
        check("basic_sat", 32'(sat_count), 32'd1);
`endif
        tick();
        check("basic_consumed", 32'(m_valid), 32'd0);

        // Saturation high and mid-range rounding: features 3,2,2,2
        push(16'h7FFF, 1'b0);
        push(16'h0080, 1'b0);
        push(16'h0000, 1'b0);
        push(16'h0000, 1'b1);
        check("sat_m_data", 32'(m_data), 32'hAB);
`ifdef LAYER0_IN_SAT_CNT_EN
        check("sat_count2", 32'(sat_count), 32'd2);
`endif
        tick();

        // Backpressure: two back-to-back frames, 0xFF then 0xAA
        m_ready = 1'b0;
        for (int i = 0; i < 4; i++) push(16'h0100, i == 3);
        check("bp_first_valid", 32'(m_valid), 32'd1);
        check("bp_first_data", 32'(m_data), 32'hFF);
        for (int i = 0; i < 4; i++) push(16'h0000, i == 3);
        check("bp_wait_s_ready", 32'(s_ready), 32'd0);
        check("bp_hold_data", 32'(m_data), 32'hFF);
        tick();
        tick();
        check("bp_hold_data2", 32'(m_data), 32'hFF);
        check("bp_hold_valid", 32'(m_valid), 32'd1);
        m_ready = 1'b1;
        tick();
        check("bp_second_valid", 32'(m_valid), 32'd1);
        check("bp_second_data", 32'(m_data), 32'hAA);
        check("bp_ready_back", 32'(s_ready), 32'd1);
        tick();
        check("bp_drained", 32'(m_valid), 32'd0);

        // Early s_last on 2nd sample
        push(16'h0000, 1'b0);
        push(16'h0000, 1'b1);
        check("early_err", 32'(frame_err), 32'd1);
        check("early_no_valid", 32'(m_valid), 32'd0);
        tick();
        check("early_err_pulse", 32'(frame_err), 32'd0);
        push(16'h0100, 1'b0);
        push(16'h0000, 1'b0);
        push(16'hFF00, 1'b0);
        push(16'h0100, 1'b1);
        check("early_next_valid", 32'(m_valid), 32'd1);
        check("early_next_data", 32'(m_data), 32'hDB);
        tick();

        // Missing s_last on 4th sample
        for (int i = 0; i < 4; i++) push(16'h0100, 1'b0);
        check("miss_err", 32'(frame_err), 32'd1);
        check("miss_no_valid", 32'(m_valid), 32'd0);
        for (int i = 0; i < 4; i++) push(16'hFF00, i == 3);
        check("miss_next_data", 32'(m_data), 32'h55);
        check("miss_next_valid", 32'(m_valid), 32'd1);
        tick();

        // Reset while in WAIT
        m_ready = 1'b0;
        for (int i = 0; i < 4; i++) push(16'h7FFF, i == 3);
        for (int i = 0; i < 4; i++) push(16'h0000, i == 3);
        check("rw_in_wait", 32'(s_ready), 32'd0);
        rst = 1'b1;
        #1;
        check("rw_m_valid", 32'(m_valid), 32'd0);
        check("rw_s_ready", 32'(s_ready), 32'd0);
        tick();
        rst = 1'b0;
        #1;
        check("rw_release_ready", 32'(s_ready), 32'd1);
        check("rw_frame_err", 32'(frame_err), 32'd0);
`ifdef LAYER0_IN_SAT_CNT_EN
        check("rw_sat_clear", 32'(sat_count), 32'd0);
`endif
        tick();
        check("rw_valid_after", 32'(m_valid), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
